// File: rtl/snake_pkg.sv
// Shared types for the snake game-flow controller: state encoding and bus widths.
package snake_pkg;

    localparam int STATE_W = 3;
    localparam int DIR_W   = 5;
    localparam int SCORE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_OVER    = 3'd3,
        ST_WIN     = 3'd4,
        ST_RESTART = 3'd5
    } state_t;

endpackage

// File: rtl/game_sequencer_if.sv
// Signal bundle between the key decoder / game blocks and the game sequencer.
interface game_sequencer_if;
    import snake_pkg::*;

    logic               vblnk;
    logic               start_key;
    logic               pause_key;
    logic [DIR_W-1:0]   direction;
    logic               game_over;
    logic               victory;
    logic [SCORE_W-1:0] score;
    logic               move_tick;
    logic               game_rst;
    logic               run;
    logic [STATE_W-1:0] state;

    modport master (
        output vblnk, start_key, pause_key, direction, game_over, victory, score,
        input  move_tick, game_rst, run, state
    );

    modport slave (
        input  vblnk, start_key, pause_key, direction, game_over, victory, score,
        output move_tick, game_rst, run, state
    );

endinterface

// File: rtl/game_sequencer_step_timer.sv
// Frame-synchronous step timer: vblnk edge detect, score-dependent period, frame counter.
module step_timer
    import snake_pkg::*;
#(
    parameter int BASE_FRAMES   = 12,
    parameter int MIN_FRAMES    = 4,
    parameter int SPEEDUP_SHIFT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vblnk,
    input  logic [SCORE_W-1:0] score,
    input  logic               enable,
    input  logic               hold,
    input  logic               clear,
    output logic               tick
);

    localparam int CNT_W = $clog2(BASE_FRAMES + 1);

    logic             vblnk_d;
    logic             frame_pulse;
    logic             advance;
    logic             last_frame;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period;
    int               period_raw;

    // Signed int arithmetic keeps a large score from wrapping the period upward.
    always_comb begin
        period_raw = BASE_FRAMES - int'(score >> SPEEDUP_SHIFT);
        period     = (period_raw < MIN_FRAMES) ? CNT_W'(MIN_FRAMES) : CNT_W'(period_raw);
    end

    assign frame_pulse = vblnk & ~vblnk_d;
    assign advance     = frame_pulse & enable & ~hold & ~clear;
    assign last_frame  = (frame_cnt == period_q - CNT_W'(1));

    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            vblnk_d   <= 1'b0;
            frame_cnt <= '0;
            period_q  <= CNT_W'(BASE_FRAMES);
            tick      <= 1'b0;
        end else begin
            vblnk_d <= vblnk;
            tick    <= advance & last_frame;
            if (clear) begin
                frame_cnt <= '0;
                period_q  <= period;
            end else if (advance) begin
                if (last_frame) begin
                    frame_cnt <= '0;
                    period_q  <= period;
                end else begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Snake game-flow FSM: IDLE/RUN/PAUSE/OVER/WIN/RESTART, movement ticks and soft-reset pulse.
module game_sequencer
    import snake_pkg::*;
#(
    parameter int BASE_FRAMES   = 12,
    parameter int MIN_FRAMES    = 4,
    parameter int SPEEDUP_SHIFT = 0,
    parameter int RST_CYCLES    = 16
) (
    input  logic             clk,
    input  logic             reset,
    game_sequencer_if.slave  bus
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t           state_q;
    state_t           state_d;
    logic [RST_W-1:0] rst_cnt;
    logic             rst_done;
    logic             run_q;
    logic             game_rst_q;
    logic             timer_enable;
    logic             timer_hold;
    logic             timer_clear;
    logic             move_tick;

    assign rst_done = (rst_cnt == RST_W'(RST_CYCLES - 1));

    // NOTE: state_d is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_key || (bus.direction != '0)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.victory)        state_d = ST_WIN;
                else if (bus.game_over) state_d = ST_OVER;
                else if (bus.pause_key) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (bus.pause_key) state_d = ST_RUN;
            end
            ST_OVER, ST_WIN: begin
                if (bus.start_key) state_d = ST_RESTART;
            end
            ST_RESTART: begin
                if (rst_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counting only while RUN persists suppresses a tick on the cycle RUN is left.
    always_comb begin
        timer_enable = (state_q == ST_RUN) && (state_d == ST_RUN);
        timer_hold   = (state_q == ST_PAUSE);
        timer_clear  = (state_q == ST_IDLE) || (state_q == ST_RESTART) ||
                       ((state_q == ST_RUN) && ((state_d == ST_OVER) || (state_d == ST_WIN)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rst_cnt    <= '0;
            run_q      <= 1'b0;
            game_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= (state_d == ST_RUN);
            game_rst_q <= (state_d == ST_RESTART);
            rst_cnt    <= ((state_q == ST_RESTART) && !rst_done) ? rst_cnt + RST_W'(1) : '0;
        end
    end

    step_timer #(
        .BASE_FRAMES   (BASE_FRAMES),
        .MIN_FRAMES    (MIN_FRAMES),
        .SPEEDUP_SHIFT (SPEEDUP_SHIFT)
    ) u_step_timer (
        .clk    (clk),
        .reset  (reset),
        .vblnk  (bus.vblnk),
        .score  (bus.score),
        .enable (timer_enable),
        .hold   (timer_hold),
        .clear  (timer_clear),
        .tick   (move_tick)
    );

    assign bus.move_tick = move_tick;
    assign bus.game_rst  = game_rst_q;
    assign bus.run       = run_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: FSM transition table plus tick, pause, restart and abort sequences.
module tb_game_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    game_sequencer_if bus();

    game_sequencer #(
        .BASE_FRAMES   (12),
        .MIN_FRAMES    (4),
        .SPEEDUP_SHIFT (0),
        .RST_CYCLES    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       start_key;
        logic       pause_key;
        logic [4:0] direction;
        logic       game_over;
        logic       victory;
        int         exp_state;
        int         exp_run;
        int         exp_game_rst;
    } vec_t;

    vec_t vecs[12];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.vblnk     = 1'b0;
        bus.start_key = 1'b0;
        bus.pause_key = 1'b0;
        bus.direction = '0;
        bus.game_over = 1'b0;
        bus.victory   = 1'b0;
    endtask

    task automatic pulse_pause();
        bus.pause_key = 1'b1;
        cyc();
        bus.pause_key = 1'b0;
    endtask

    // One vblnk rising edge; t_first is move_tick just after the sampling edge.
    task automatic frame(output int t_first, output int t_rest);
        bus.vblnk = 1'b1;
        cyc();
        t_first   = int'(bus.move_tick);
        bus.vblnk = 1'b0;
        t_rest    = 0;
        repeat (3) begin
            cyc();
            t_rest += int'(bus.move_tick);
        end
    endtask

    task automatic frames_no_tick(input string name, input int count);
        int tf, tr, total;
        total = 0;
        for (int i = 0; i < count; i++) begin
            frame(tf, tr);
            total += tf + tr;
        end
        check(name, total, 0);
    endtask

    task automatic frames_to_tick(input string name, input int expected);
        int tf, tr, n;
        bit found;
        n     = 31;
        found = 1'b0;
        tf    = 0;
        tr    = 0;
        for (int i = 1; i <= 30; i++) begin
            frame(tf, tr);
            if ((tf + tr) != 0) begin
                n     = i;
                found = 1'b1;
                break;
            end
        end
        check({name, "_frames"}, n, expected);
        if (found) begin
            check({name, "_latency"}, tf, 1);
            check({name, "_width"}, tr, 0);
        end
    endtask

    initial begin
        vecs[0]  = '{"idle_pause_ign",   1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 0, 0, 0};
        vecs[1]  = '{"idle_over_ign",    1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 0, 0, 0};
        vecs[2]  = '{"idle_dir_run",     1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1, 1, 0};
        vecs[3]  = '{"run_start_ign",    1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1, 1, 0};
        vecs[4]  = '{"run_pause",        1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 2, 0, 0};
        vecs[5]  = '{"pause_events_ign", 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 2, 0, 0};
        vecs[6]  = '{"pause_start_ign",  1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2, 0, 0};
        vecs[7]  = '{"pause_resume",     1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1, 1, 0};
        vecs[8]  = '{"run_over_prio",    1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 3, 0, 0};
        vecs[9]  = '{"over_pause_ign",   1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 3, 0, 0};
        vecs[10] = '{"over_dir_ign",     1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 3, 0, 0};
        vecs[11] = '{"over_restart",     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5, 0, 1};

        clear_inputs();
        bus.score = '0;
        reset     = 1'b1;
        cyc();
        cyc();
        check("rst_state", int'(bus.state), 0);
        check("rst_run", int'(bus.run), 0);
        check("rst_move_tick", int'(bus.move_tick), 0);
        check("rst_game_rst", int'(bus.game_rst), 0);
        reset = 1'b0;
        cyc();

        for (int i = 0; i < 12; i++) begin
            bus.start_key = vecs[i].start_key;
            bus.pause_key = vecs[i].pause_key;
            bus.direction = vecs[i].direction;
            bus.game_over = vecs[i].game_over;
            bus.victory   = vecs[i].victory;
            cyc();
            clear_inputs();
            check({vecs[i].name, "_state"}, int'(bus.state), vecs[i].exp_state);
            check({vecs[i].name, "_run"}, int'(bus.run), vecs[i].exp_run);
            check({vecs[i].name, "_game_rst"}, int'(bus.game_rst), vecs[i].exp_game_rst);
            check({vecs[i].name, "_move_tick"}, int'(bus.move_tick), 0);
        end

        // RESTART cycles 2..16, with a stray start_key that must be ignored.
        for (int k = 2; k <= 16; k++) begin
            bus.start_key = (k == 5);
            cyc();
            check("restart_state", int'(bus.state), 5);
            check("restart_game_rst", int'(bus.game_rst), 1);
        end
        bus.start_key = 1'b0;
        cyc();
        check("restart_end_state", int'(bus.state), 0);
        check("restart_end_game_rst", int'(bus.game_rst), 0);

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.score     = 4'd0;
        bus.direction = 5'b00001;
        cyc();
        bus.direction = '0;
        check("start_state", int'(bus.state), 1);
        check("start_run", int'(bus.run), 1);

        frames_to_tick("score0_first", 12);
        bus.score = 4'd3;
        frames_to_tick("score3_old_period", 12);
        frames_to_tick("score3_new_period", 9);
        bus.score = 4'd10;
        frames_to_tick("score10_old_period", 9);
        frames_to_tick("score10_floor", 4);
        bus.score = 4'd0;
        frames_to_tick("score0_old_period", 4);

        frames_no_tick("pre_pause_ticks", 5);
        pulse_pause();
        check("pause_state", int'(bus.state), 2);
        frames_no_tick("paused_ticks", 20);
        pulse_pause();
        check("resume_state", int'(bus.state), 1);
        frames_to_tick("after_resume", 7);

        frames_no_tick("pre_collision_ticks", 11);
        bus.vblnk     = 1'b1;
        bus.victory   = 1'b1;
        bus.game_over = 1'b1;
        bus.pause_key = 1'b1;
        cyc();
        clear_inputs();
        check("simul_state", int'(bus.state), 4);
        check("simul_move_tick", int'(bus.move_tick), 0);
        check("simul_run", int'(bus.run), 0);
        cyc();
        check("simul_move_tick_late", int'(bus.move_tick), 0);

        bus.start_key = 1'b1;
        cyc();
        bus.start_key = 1'b0;
        check("win_restart_state", int'(bus.state), 5);
        check("win_restart_game_rst", int'(bus.game_rst), 1);
        repeat (4) cyc();
        check("abort_pre_game_rst", int'(bus.game_rst), 1);
        reset = 1'b1;
        cyc();
        check("abort_game_rst", int'(bus.game_rst), 0);
        check("abort_state", int'(bus.state), 0);
        reset = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
